// File: rtl/myram_loader_pkg.sv
// Shared types for the table loader: FSM state encoding and a table-depth helper.
package myram_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    // Evaluated in 64 bits so wide address parameters cannot overflow the depth.
    function automatic longint unsigned calc_depth(input int bits);
        return 64'd1 << bits;
    endfunction

endpackage

// File: rtl/myram_loader_if.sv
// Load/read bus of the table loader; the producer/reader drives master, the loader is slave.
interface myram_loader_if #(
    parameter int addr_bits = 1,
    parameter int data_bits = 1
);

    logic                 load_start;
    logic                 in_valid;
    logic [data_bits-1:0] in_data;
    logic                 in_ready;
    logic [addr_bits-1:0] wr_addr;
    logic                 table_ready;
    logic [addr_bits-1:0] addr;
    logic [data_bits-1:0] dout;

    modport master (
        output load_start, in_valid, in_data, addr,
        input  in_ready, wr_addr, table_ready, dout
    );

    modport slave (
        input  load_start, in_valid, in_data, addr,
        output in_ready, wr_addr, table_ready, dout
    );

endinterface

// File: rtl/myram_loader_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module myram
    import myram_loader_pkg::*;
#(
    parameter int addr_bits = 1,
    parameter int data_bits = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [addr_bits-1:0] waddr_i,
    input  logic [data_bits-1:0] wdata_i,
    input  logic [addr_bits-1:0] raddr_i,
    output logic [data_bits-1:0] rdata_o
);

    localparam longint unsigned DEPTH = calc_depth(addr_bits);

    logic [data_bits-1:0] mem_q [0:DEPTH-1];
    logic [data_bits-1:0] rdata_q;

    // Storage has no reset so table contents survive a reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Non-blocking read of the array returns the pre-write word on a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/myram_loader.sv
// Streams a full table of words into myram, then flags it readable via table_ready.
module myram_loader
    import myram_loader_pkg::*;
#(
    parameter int addr_bits = 1,
    parameter int data_bits = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    myram_loader_if.slave  bus
);

    localparam logic [addr_bits-1:0] LAST_ADDR = '1;

    state_e               state_q, state_d;
    logic [addr_bits-1:0] wr_addr_q, wr_addr_d;
    logic                 table_ready_q, table_ready_d;
    logic                 in_ready;
    logic                 we;

    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        table_ready_d = table_ready_q;
        in_ready      = 1'b0;
        we            = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.load_start) begin
                    state_d       = LOAD;
                    wr_addr_d     = '0;
                    table_ready_d = 1'b0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                // A restart wins over a word offered on the same cycle.
                if (bus.load_start) begin
                    wr_addr_d = '0;
                end else if (bus.in_valid) begin
                    we        = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d       = DONE;
                        table_ready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_addr_q     <= '0;
            table_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            table_ready_q <= table_ready_d;
        end
    end

    myram #(
        .addr_bits (addr_bits),
        .data_bits (data_bits)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we & rst_n),
        .waddr_i (wr_addr_q),
        .wdata_i (bus.in_data),
        .raddr_i (bus.addr),
        .rdata_o (bus.dout)
    );

    assign bus.in_ready    = in_ready;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.table_ready = table_ready_q;

endmodule

// File: tb/tb_myram_loader.sv
// Directed scenario bench for myram_loader with an 8 x 8-bit table.
module tb_myram_loader;

    localparam int AW = 3;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   testsRun = 0;
    int   testsFailed = 0;

    always #5 clk = ~clk;

    myram_loader_if #(.addr_bits(AW), .data_bits(DW)) bus ();

    myram_loader #(.addr_bits(AW), .data_bits(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Outputs are sampled 1 time unit after the rising edge, once they have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input logic [7:0] first, input int startAddr);
        for (int i = startAddr; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(int'(first) + i);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.addr       = 3'd0;
        tick();
        tick();
        testsRun++; if (bus.in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        testsRun++; if (bus.table_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_table_ready: got %b expected 0", bus.table_ready); end
        testsRun++; if (bus.wr_addr !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", bus.wr_addr); end
        testsRun++; if (bus.dout !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_dout: got %h expected 00", bus.dout); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_load();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        testsRun++; if (bus.in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_in_ready: got %b expected 1", bus.in_ready); end
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h10 + i);
            testsRun++; if (bus.wr_addr !== 3'(i)) begin testsFailed++; $display("[TB] FAIL full_wr_addr: got %0d expected %0d", bus.wr_addr, i); end
            testsRun++; if (bus.table_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_early_ready: got %b expected 0 before word %0d", bus.table_ready, i); end
            tick();
        end
        bus.in_valid = 1'b0;
        testsRun++; if (bus.table_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_table_ready: got %b expected 1", bus.table_ready); end
        testsRun++; if (bus.wr_addr !== 3'd0) begin testsFailed++; $display("[TB] FAIL full_wr_addr_wrap: got %0d expected 0", bus.wr_addr); end
        testsRun++; if (bus.in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_done_in_ready: got %b expected 0", bus.in_ready); end
        for (int i = 0; i < 8; i++) begin
            bus.addr = 3'(i);
            tick();
            testsRun++; if (bus.dout !== 8'(8'h10 + i)) begin testsFailed++; $display("[TB] FAIL full_read[%0d]: got %h expected %h", i, bus.dout, 8'(8'h10 + i)); end
        end
    endtask

    // Table holds 0x10..0x17 on entry, so address 2 starts as 0x12.
    task automatic test_collision();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h50;
        tick();
        bus.in_data    = 8'h51;
        tick();
        bus.in_data    = 8'h55;
        bus.addr       = 3'd2;
        testsRun++; if (bus.wr_addr !== 3'd2) begin testsFailed++; $display("[TB] FAIL coll_wr_addr: got %0d expected 2", bus.wr_addr); end
        tick();
        bus.in_valid   = 1'b0;
        testsRun++; if (bus.dout !== 8'h12) begin testsFailed++; $display("[TB] FAIL coll_read_first: got %h expected 12", bus.dout); end
        tick();
        testsRun++; if (bus.dout !== 8'h55) begin testsFailed++; $display("[TB] FAIL coll_read_new: got %h expected 55", bus.dout); end
        load_words(8'h10, 3);
        testsRun++; if (bus.table_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL coll_table_ready: got %b expected 1", bus.table_ready); end
    endtask

    task automatic test_stalls();
        int k = 0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int c = 0; c < 22 && k < 8; c++) begin
            bus.in_valid = (c % 3 == 0);
            bus.in_data  = 8'(8'h20 + k);
            testsRun++; if (bus.wr_addr !== 3'(k)) begin testsFailed++; $display("[TB] FAIL stall_wr_addr: got %0d expected %0d at cycle %0d", bus.wr_addr, k, c); end
            testsRun++; if (bus.table_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_early_ready: got %b expected 0 at cycle %0d", bus.table_ready, c); end
            tick();
            if (c % 3 == 0) k++;
        end
        bus.in_valid = 1'b0;
        testsRun++; if (bus.table_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_table_ready: got %b expected 1", bus.table_ready); end
        testsRun++; if (bus.wr_addr !== 3'd0) begin testsFailed++; $display("[TB] FAIL stall_wr_addr_wrap: got %0d expected 0", bus.wr_addr); end
        for (int i = 0; i < 8; i++) begin
            bus.addr = 3'(i);
            tick();
            testsRun++; if (bus.dout !== 8'(8'h20 + i)) begin testsFailed++; $display("[TB] FAIL stall_read[%0d]: got %h expected %h", i, bus.dout, 8'(8'h20 + i)); end
        end
    endtask

    // Table holds 0x20..0x27 on entry; address 3 must still read 0x23 after the restart.
    task automatic test_restart();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'hA0 + i);
            tick();
        end
        bus.load_start = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'hEE;
        bus.addr       = 3'd3;
        tick();
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        testsRun++; if (bus.wr_addr !== 3'd0) begin testsFailed++; $display("[TB] FAIL restart_wr_addr: got %0d expected 0", bus.wr_addr); end
        testsRun++; if (bus.in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL restart_in_ready: got %b expected 1", bus.in_ready); end
        testsRun++; if (bus.table_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL restart_table_ready: got %b expected 0", bus.table_ready); end
        tick();
        testsRun++; if (bus.dout !== 8'h23) begin testsFailed++; $display("[TB] FAIL restart_no_write: got %h expected 23", bus.dout); end
        load_words(8'hB0, 0);
        testsRun++; if (bus.table_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL restart_done: got %b expected 1", bus.table_ready); end
        for (int i = 0; i < 8; i++) begin
            bus.addr = 3'(i);
            tick();
            testsRun++; if (bus.dout !== 8'(8'hB0 + i)) begin testsFailed++; $display("[TB] FAIL restart_read[%0d]: got %h expected %h", i, bus.dout, 8'(8'hB0 + i)); end
        end
    endtask

    // Reset also sees load_start and a valid word, both of which it must override.
    task automatic test_reset_during_load();
        logic [7:0] expected [8];
        expected = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'hB5, 8'hB6, 8'hB7};
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h60 + i);
            tick();
        end
        rst_n          = 1'b0;
        bus.load_start = 1'b1;
        bus.in_data    = 8'hEE;
        tick();
        testsRun++; if (bus.in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstload_in_ready: got %b expected 0", bus.in_ready); end
        testsRun++; if (bus.table_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstload_table_ready: got %b expected 0", bus.table_ready); end
        testsRun++; if (bus.wr_addr !== 3'd0) begin testsFailed++; $display("[TB] FAIL rstload_wr_addr: got %0d expected 0", bus.wr_addr); end
        testsRun++; if (bus.dout !== 8'h00) begin testsFailed++; $display("[TB] FAIL rstload_dout: got %h expected 00", bus.dout); end
        rst_n          = 1'b1;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.addr = 3'(i);
            tick();
            testsRun++; if (bus.dout !== expected[i]) begin testsFailed++; $display("[TB] FAIL rstload_read[%0d]: got %h expected %h", i, bus.dout, expected[i]); end
        end
    endtask

    task automatic test_ignored_input();
        logic [7:0] expected [8];
        expected = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'hB5, 8'hB6, 8'hB7};
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        tick();
        tick();
        testsRun++; if (bus.in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_in_ready: got %b expected 0", bus.in_ready); end
        testsRun++; if (bus.wr_addr !== 3'd0) begin testsFailed++; $display("[TB] FAIL idle_wr_addr: got %0d expected 0", bus.wr_addr); end
        for (int i = 0; i < 8; i++) begin
            bus.addr = 3'(i);
            tick();
            testsRun++; if (bus.dout !== expected[i]) begin testsFailed++; $display("[TB] FAIL idle_read[%0d]: got %h expected %h", i, bus.dout, expected[i]); end
        end
        bus.in_valid   = 1'b0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        load_words(8'h70, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        tick();
        tick();
        testsRun++; if (bus.in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL done_in_ready: got %b expected 0", bus.in_ready); end
        testsRun++; if (bus.wr_addr !== 3'd0) begin testsFailed++; $display("[TB] FAIL done_wr_addr: got %0d expected 0", bus.wr_addr); end
        testsRun++; if (bus.table_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL done_table_ready: got %b expected 1", bus.table_ready); end
        for (int i = 0; i < 8; i++) begin
            bus.addr = 3'(i);
            tick();
            testsRun++; if (bus.dout !== 8'(8'h70 + i)) begin testsFailed++; $display("[TB] FAIL done_read[%0d]: got %h expected %h", i, bus.dout, 8'(8'h70 + i)); end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_collision();
        test_stalls();
        test_restart();
        test_reset_during_load();
        test_ignored_input();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/myram_loader.md
MYRAM_LOADER -- requirements
Module: myram_loader

Interface
REQ-001 SHALL have parameter addr_bits, default 1: table address width; depth = 2**addr_bits words.
REQ-002 SHALL have parameter data_bits, default 1: table word width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port load_start  input  1  pulse that begins a full-table load at address 0.
REQ-006 SHALL have port in_valid  input  1  in_data holds a word to be written.
REQ-007 SHALL have port in_data  input  data_bits  word to be written.
REQ-008 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-009 SHALL have port wr_addr  output  addr_bits  address the next accepted word is written to.
REQ-010 SHALL have port table_ready  output  1  a complete load has finished and the table is readable.
REQ-011 SHALL have port addr  input  addr_bits  read address.
REQ-012 SHALL have port dout  output  data_bits  registered read data.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD and DONE.
REQ-014 SHALL move from IDLE or DONE to LOAD when load_start=1, clearing wr_addr to 0 and table_ready to 0 on that edge.
REQ-015 SHALL drive in_ready=1 only in LOAD; a word transfers on any edge with in_valid=1 and in_ready=1.
REQ-016 SHALL write in_data to memory[wr_addr] on each transfer and increment wr_addr by 1 modulo depth.
REQ-017 SHALL, on the transfer at wr_addr = depth-1, go to DONE, set table_ready=1 on that edge and wrap wr_addr to 0.
REQ-018 SHALL hold wr_addr and state unchanged in LOAD when in_valid=0 (stalls of any length allowed).
REQ-019 SHALL ignore in_valid and in_data in IDLE and DONE.
REQ-020 SHALL treat load_start=1 in LOAD as a restart: wr_addr goes to 0 and the in_data presented that cycle is not written.
REQ-021 SHALL register dout <= memory[addr] every edge in every state, giving 1-cycle read latency.
REQ-022 SHALL return old data (read-first) when addr equals the address written on the same edge.
REQ-023 SHALL not define dout content validity; consumers use dout only while table_ready=1.

Reset
REQ-024 SHALL, on an edge with rst_n=0, enter IDLE with wr_addr=0, table_ready=0 and dout=0.
REQ-025 SHALL leave memory contents unchanged on reset, including reset during LOAD.
REQ-026 SHALL give rst_n=0 priority over load_start and in_valid on the same edge.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, LOAD, DONE) in the shared package and import it from there.
REQ-028 SHALL instantiate a single sub-module myram: a simple dual-port RAM (one write port, one registered read port, read-first), parameterised by addr_bits and data_bits, depth 2**addr_bits.
REQ-029 SHALL compute depth as a 64-bit-safe localparam so that wide addr_bits do not overflow.

Verification (addr_bits=3, data_bits=8)
REQ-030 SHALL cover a full load: load_start, then 8 back-to-back words 0x10..0x17 -> table_ready=1 on the edge of the 8th word, wr_addr=0, and reading addr 0..7 returns 0x10..0x17 one cycle after each address.
REQ-031 SHALL cover stalls: in_valid toggled 1,0,0,1,... over a full load -> exactly 8 writes, wr_addr steps only on transfers, table_ready rises only after the 8th transfer.
REQ-032 SHALL cover restart: load_start after 3 words (0xA0..0xA2), then 8 words 0xB0..0xB7 -> table holds 0xB0..0xB7; the in_data presented with the restart is not written.
REQ-033 SHALL cover reset during LOAD: rst_n=0 after 5 words -> IDLE, table_ready=0, in_ready=0, dout=0; addresses 0..4 keep the written words.
REQ-034 SHALL cover read-first collision: addr=2 while 0x55 is written to address 2 over old value 0x12 -> dout=0x12 next cycle, then 0x55 the cycle after.
REQ-035 SHALL cover ignored input: in_valid=1 with 0xFF in IDLE and in DONE -> in_ready=0, no memory change, wr_addr unchanged.
